// File: rtl/univ_shift_reg.sv
// univ_shift_reg: universal shift register with parallel load, shifts,
// rotates, single-step operation and counted multi-step operation.
// Optional feature: define UNIV_SHIFT_REG_ROTATE_EN to enable the rotate
// modes (100/101). Without it those modes act as hold and cannot start a
// multi-step operation.
module univ_shift_reg #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] SET_VALUE = {WIDTH{1'b1}}
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       set,
    input  logic                       en,
    input  logic [2:0]                 mode,
    input  logic [WIDTH-1:0]           data_in,
    input  logic                       ser_in,
    input  logic                       start,
    input  logic [$clog2(WIDTH):0]     shamt,
    output logic [WIDTH-1:0]           q,
    output logic                       ser_out,
    output logic                       busy,
    output logic                       done
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [2:0] {
        MODE_HOLD = 3'b000,
        MODE_LOAD = 3'b001,
        MODE_SHL  = 3'b010,
        MODE_SHR  = 3'b011,
        MODE_ROL  = 3'b100,
        MODE_ROR  = 3'b101
    } mode_t;

    mode_t          mode_r;     // mode latched when a multi-step op is accepted
    logic [CW-1:0]  cnt;        // steps still to perform
    mode_t          op_mode;
    logic [WIDTH-1:0] step_q;
    logic           step_out;
    logic           accept;
    logic [CW-1:0]  shamt_c;

    // Result of one operation of the active mode (latched mode while busy).
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        op_mode  = busy ? mode_r : mode_t'(mode);
        step_q   = q;
        step_out = ser_out;
        case (op_mode)
            MODE_LOAD: step_q = data_in;
            MODE_SHL: begin
                step_q   = {q[WIDTH-2:0], ser_in};
                step_out = q[WIDTH-1];
            end
            MODE_SHR: begin
                step_q   = {ser_in, q[WIDTH-1:1]};
                step_out = q[0];
            end
`ifdef UNIV_SHIFT_REG_ROTATE_EN
            MODE_ROL: begin
                step_q   = {q[WIDTH-2:0], q[WIDTH-1]};
                step_out = q[WIDTH-1];
            end
            MODE_ROR: begin
                step_q   = {q[0], q[WIDTH-1:1]};
                step_out = q[0];
            end
`endif
            default: ;
        endcase
    end

    // Which modes may start a multi-step operation, and the clamped count.
    always_comb begin
        accept = 1'b0;
        case (mode_t'(mode))
            MODE_SHL, MODE_SHR: accept = start;
`ifdef UNIV_SHIFT_REG_ROTATE_EN
            MODE_ROL, MODE_ROR: accept = start;
`endif
            default: accept = 1'b0;
        endcase
        shamt_c = (shamt > CW'(WIDTH)) ? CW'(WIDTH) : shamt;
    end

    // Register update in priority order: reset, set, stepping, accept, single step.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rst) begin
            q       <= '0;
            ser_out <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            cnt     <= '0;
            mode_r  <= MODE_HOLD;
        end else begin
            done <= 1'b0;
            if (set) begin
                q    <= SET_VALUE;
                busy <= 1'b0;
                cnt  <= '0;
            end else if (busy) begin
                q       <= step_q;
                ser_out <= step_out;
                cnt     <= cnt - 1'b1;
                if (cnt == CW'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end else if (accept) begin
                mode_r <= mode_t'(mode);
                cnt    <= shamt_c;
                busy   <= (shamt_c != '0);
                done   <= (shamt_c == '0);
            end else if (en) begin
                q       <= step_q;
                ser_out <= step_out;
            end
        end
    end

endmodule

// File: tb/tb_univ_shift_reg.sv
// Scoreboard bench for univ_shift_reg: the driver computes the expected
// outputs after each edge with a behavioural model and queues them; a monitor
// on the falling edge pops and compares.
module tb_univ_shift_reg;

    localparam int W  = 8;
    localparam int SW = $clog2(W) + 1;
`ifdef UNIV_SHIFT_REG_ROTATE_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, set, en, ser_in, start;
    logic [2:0]    mode;
    logic [W-1:0]  data_in;
    logic [SW-1:0] shamt;
    logic [W-1:0]  q;
    logic          ser_out, busy, done;

    always #5 clk = ~clk;

    univ_shift_reg #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .set(set), .en(en), .mode(mode),
        .data_in(data_in), .ser_in(ser_in), .start(start), .shamt(shamt),
        .q(q), .ser_out(ser_out), .busy(busy), .done(done)
    );

    typedef struct {
        logic [W-1:0] q;
        logic         so;
        logic         busy;
        logic         done;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Behavioural model state
    logic [31:0] m_q;
    logic        m_so, m_busy, m_done;
    int          m_left;
    logic [2:0]  m_mode;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit multi_ok(input logic [2:0] md);
        return (md == 3'd2) || (md == 3'd3) || (ROT && (md == 3'd4 || md == 3'd5));
    endfunction

    // One operation of mode md on the model register.
    task automatic model_apply(input logic [2:0] md, input logic s);
        logic [31:0] mask, sv, b;
        mask = (32'h1 << W) - 1;
        sv   = {31'b0, s};
        case (md)
            3'd1: m_q = {{(32-W){1'b0}}, data_in};
            3'd2: begin m_so = m_q[W-1]; m_q = ((m_q << 1) | sv) & mask; end
            3'd3: begin m_so = m_q[0];   m_q = (m_q >> 1) | (sv << (W-1)); end
            3'd4: if (ROT) begin
                b = {31'b0, m_q[W-1]}; m_so = m_q[W-1]; m_q = ((m_q << 1) | b) & mask;
            end
            3'd5: if (ROT) begin
                b = {31'b0, m_q[0]}; m_so = m_q[0]; m_q = (m_q >> 1) | (b << (W-1));
            end
            default: ;
        endcase
    endtask

    // Model reaction to a rising edge with the inputs currently applied.
    task automatic model_edge();
        int n;
        if (!rst) begin
            m_q = 0; m_so = 0; m_busy = 0; m_done = 0; m_left = 0; m_mode = 0;
        end else if (set) begin
            m_q = {{(32-W){1'b0}}, {W{1'b1}}}; m_busy = 0; m_done = 0; m_left = 0;
        end else if (m_busy) begin
            model_apply(m_mode, ser_in);
            m_left = m_left - 1;
            m_busy = (m_left != 0);
            m_done = (m_left == 0);
        end else if (start && multi_ok(mode)) begin
            n = (int'(shamt) > W) ? W : int'(shamt);
            m_mode = mode; m_left = n;
            m_busy = (n != 0);
            m_done = (n == 0);
        end else begin
            m_done = 0;
            if (en) model_apply(mode, ser_in);
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, queue the expectation.
    task automatic cyc(input logic r, input logic s, input logic e, input logic [2:0] md,
                       input logic [W-1:0] d, input logic si, input logic go,
                       input logic [SW-1:0] sh);
        exp_t x;
        rst = r; set = s; en = e; mode = md; data_in = d; ser_in = si; start = go; shamt = sh;
        @(posedge clk);
        model_edge();
        x.q = m_q[W-1:0]; x.so = m_so; x.busy = m_busy; x.done = m_done;
        sb.push_back(x);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1, 0, 0, 3'd0, '0, 1'b0, 1'b0, '0);
    endtask

    // Monitor: compare the DUT outputs against the queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("q",       {24'b0, q},       {24'b0, e.q});
            check("ser_out", {31'b0, ser_out}, {31'b0, e.so});
            check("busy",    {31'b0, busy},    {31'b0, e.busy});
            check("done",    {31'b0, done},    {31'b0, e.done});
        end
    end

    initial begin
        // Reset with set, en and a load all asserted
        cyc(0, 1, 1, 3'd1, 8'hA7, 1'b1, 1'b1, 4'd3);
        // Load then single left shift with ser_in=1
        cyc(1, 0, 1, 3'd1, 8'hA7, 1'b0, 1'b0, '0);
        cyc(1, 0, 1, 3'd2, 8'h00, 1'b1, 1'b0, '0);
        // en=0 holds
        cyc(1, 0, 0, 3'd3, 8'h55, 1'b0, 1'b0, '0);
        // Single right shift, rotates (hold without rotate build), mode 110
        cyc(1, 0, 1, 3'd3, 8'h00, 1'b0, 1'b0, '0);
        cyc(1, 0, 1, 3'd4, 8'h00, 1'b0, 1'b0, '0);
        cyc(1, 0, 1, 3'd5, 8'h00, 1'b1, 1'b0, '0);
        cyc(1, 0, 1, 3'd6, 8'h00, 1'b1, 1'b0, '0);
        // Multi-step rotate-left by 3 from 81 (ignored without rotate build)
        cyc(1, 0, 1, 3'd1, 8'h81, 1'b0, 1'b0, '0);
        cyc(1, 0, 0, 3'd4, 8'h00, 1'b0, 1'b1, 4'd3);
        idle(5);
        // Rotate-right start with shamt 2 (ignored without rotate build)
        cyc(1, 0, 0, 3'd5, 8'h00, 1'b0, 1'b1, 4'd2);
        idle(3);
        // Multi-step shift-left by 3 with inputs toggling while busy
        cyc(1, 0, 1, 3'd1, 8'h81, 1'b0, 1'b0, '0);
        cyc(1, 0, 0, 3'd2, 8'h00, 1'b1, 1'b1, 4'd3);
        cyc(1, 0, 1, 3'd1, 8'hFF, 1'b0, 1'b1, 4'd0);
        cyc(1, 0, 1, 3'd3, 8'h33, 1'b1, 1'b1, 4'd7);
        cyc(1, 0, 0, 3'd0, 8'h00, 1'b0, 1'b0, '0);
        idle(3);
        // Abort with set in the second busy cycle: no done pulse afterwards
        cyc(1, 0, 1, 3'd1, 8'h81, 1'b0, 1'b0, '0);
        cyc(1, 0, 0, 3'd3, 8'h00, 1'b0, 1'b1, 4'd5);
        cyc(1, 0, 0, 3'd0, 8'h00, 1'b1, 1'b0, '0);
        cyc(1, 1, 0, 3'd0, 8'h00, 1'b0, 1'b0, '0);
        idle(6);
        // Zero shift amount: done only
        cyc(1, 0, 0, 3'd3, 8'h00, 1'b0, 1'b1, 4'd0);
        idle(3);
        // Shift amount above WIDTH clamps to WIDTH
        cyc(1, 0, 1, 3'd1, 8'h5A, 1'b0, 1'b0, '0);
        cyc(1, 0, 0, 3'd3, 8'h00, 1'b1, 1'b1, 4'd15);
        idle(10);
        // Reset mid-operation
        cyc(1, 0, 0, 3'd2, 8'h00, 1'b1, 1'b1, 4'd6);
        cyc(1, 0, 0, 3'd0, 8'h00, 1'b1, 1'b0, '0);
        cyc(0, 0, 0, 3'd0, 8'h00, 1'b1, 1'b0, '0);
        idle(8);
        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 63) != 0),
                ($urandom_range(0, 31) == 0),
                1'(($urandom)),
                3'($urandom_range(0, 7)),
                W'($urandom),
                1'($urandom),
                ($urandom_range(0, 3) == 0),
                SW'($urandom_range(0, 15)));
        end
        @(negedge clk);
        #1;
        check("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
